bin2bcd_ld: RTL

Sequential binary-to-BCD converter that produces parallel-load data for a cascade of 4-bit decade up/down counters. It accepts an unsigned binary preset and converts it by iterative shift-add-3 (double dabble), one bit per clock. It then presents the BCD digits on the counters' D inputs together with a one-cycle load strobe. It sits between the control logic that computes presets in binary and the decade counter chain that counts in BCD.

---
 rtl/bin2bcd_ld.sv | 109 ++++++++++
 1 files changed

// File: rtl/bin2bcd_ld.sv
// bin2bcd_ld: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// It presents the result as parallel-load data and a load strobe for a decade counter chain.
module bin2bcd_ld #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  CDN,
    input  logic                  START,
    input  logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  LD,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVF
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]   MAXV  = pow10(DIGITS) - 64'd1;
    localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};
    localparam logic [CW-1:0] LAST  = CW'(BIN_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t          state_q;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [BW-1:0]   acc_q, acc_d, adj;
    logic [CW-1:0]   cnt_q;
    logic            ovf_pend_q;
    logic            busy_q, done_q, ovf_q;
    logic [BW-1:0]   bcd_q;

    // One double-dabble step: add 3 to every digit >= 5 independently, then shift in the next MSB.
    // The top accumulator bit falls off; that only happens when the value overflows, which is already flagged.
    always_comb begin
        adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
        acc_d = {adj[BW-2:0], sr_q[BIN_W-1]};
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
    end

    // Control FSM and all datapath/output registers; reset aborts any conversion silently.
    always_ff @(posedge CLK) begin
        if (!CDN) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        sr_q       <= BIN;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        // Overflow decided from the captured value; published only at DONE.
                        ovf_pend_q <= ({{(64-BIN_W){1'b0}}, BIN} > MAXV);
                        busy_q     <= 1'b1;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    sr_q  <= sr_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        bcd_q   <= ovf_pend_q ? NINES : acc_d;
                        ovf_q   <= ovf_pend_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign LD   = done_q;
    assign BCD  = bcd_q;
    assign OVF  = ovf_q;

endmodule
